// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) feeding HI (remainder) / LO (quotient).
// Optional macro ITER_DIVIDER_ZERO_DETECT_EN: a zero divisor finishes in one cycle and flags div_zero.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dv_mag;
  logic             sgn, neg_q, neg_r;

  logic             load, last, zero_load;
  logic [WIDTH-1:0] dd_in_mag, dv_in_mag, rem_nxt, quo_nxt;
  logic [WIDTH:0]   trial, diff;

  // cancel always wins over start, even when the divider is idle.
  assign load = (state != RUN) && start && !cancel;
  assign last = (state == RUN) && !cancel && (cnt == CNT_W'(1));

`ifdef ITER_DIVIDER_ZERO_DETECT_EN
  assign zero_load = load && (divisor == '0);
`else
  assign zero_load = 1'b0;
`endif

  always_comb begin
    dd_in_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dv_in_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    // The shifted partial remainder needs WIDTH+1 bits when the divisor magnitude is >= 2^(WIDTH-1).
    trial   = {rem, quo[WIDTH-1]};
    diff    = trial - {1'b0, dv_mag};
    rem_nxt = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  // NOTE: state and datapath registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (load) state_nxt = zero_load ? DONE : RUN;
        else      state_nxt = IDLE;
      end
      RUN: begin
        if (cancel)                  state_nxt = IDLE;
        else if (cnt == CNT_W'(1))   state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dv_mag    <= '0;
      sgn       <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      sgn    <= is_signed;
      neg_q  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r  <= is_signed & dividend[WIDTH-1];
      quo    <= dd_in_mag;
      rem    <= '0;
      dv_mag <= dv_in_mag;
      cnt    <= CNT_W'(WIDTH);
      if (zero_load) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN && !cancel) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        quotient  <= (sgn && neg_q) ? -quo_nxt : quo_nxt;
        remainder <= (sgn && neg_r) ? -rem_nxt : rem_nxt;
      end
    end
  end

`ifdef ITER_DIVIDER_ZERO_DETECT_EN
  // High only in the DONE cycle that follows a zero-divisor load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_zero <= 1'b0;
    else     div_zero <= zero_load;
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule
